// File: rtl/fcims_txn_ctrl_if.sv
// Purpose: request/result bundle between a transaction source and fcims_txn_ctrl.
// Latency: none, wires only.
// Backpressure: req is held by the master until ready; results carry no backpressure.
// master drives load/count_in/total_in/req/op/qty/uprice.
// slave (the controller) drives ready/done/err/err_code/fprice/count/total/empty/low_stock.
interface fcims_txn_ctrl_if #(
    parameter int CT_W    = 4,
    parameter int PRICE_W = 4,
    parameter int TOTAL_W = 8
);
    logic               load;
    logic [CT_W-1:0]    count_in;
    logic [TOTAL_W-1:0] total_in;
    logic               req;
    logic               ready;
    logic               op;
    logic [CT_W-1:0]    qty;
    logic [PRICE_W-1:0] uprice;
    logic               done;
    logic               err;
    logic [1:0]         err_code;
    logic [TOTAL_W-1:0] fprice;
    logic [CT_W-1:0]    count;
    logic [TOTAL_W-1:0] total;
    logic               empty;
    logic               low_stock;

    modport master (
        output load, count_in, total_in, req, op, qty, uprice,
        input  ready, done, err, err_code, fprice, count, total, empty, low_stock
    );

    modport slave (
        input  load, count_in, total_in, req, op, qty, uprice,
        output ready, done, err, err_code, fprice, count, total, empty, low_stock
    );
endinterface

// File: rtl/fcims_txn_ctrl.sv
// Purpose: buy/sell transaction controller owning stock count and cash total; shift-add line pricing, limit checks, commit/reject.
// Latency: accept at edge 0, done/err/count/total visible after edge CT_W+2; one transaction per CT_W+3 cycles.
// Backpressure: ready is low outside IDLE or while load is high; req must be held until accepted.
// Ports: clk, reset (async, active-low) plain; everything else through fcims_txn_ctrl_if.slave.
// Optional macro LOW_STOCK_ALERT_EN builds the registered low_stock comparator; otherwise low_stock is tied to 0.
module fcims_txn_ctrl #(
    parameter int CT_W       = 4,
    parameter int PRICE_W    = 4,
    parameter int TOTAL_W    = 8,
    parameter int INIT_COUNT = 0,
    parameter int INIT_TOTAL = 0,
    parameter int LOW_THRESH = 2
) (
    input  logic            clk,
    input  logic            reset,
    fcims_txn_ctrl_if.slave bus
);

    // Product must always fit, so the accumulator never overflows.
    if (TOTAL_W < CT_W + PRICE_W || CT_W < 1 || LOW_THRESH < 0) begin : g_param_err
        $error("fcims_txn_ctrl: illegal parameter combination");
    end

    localparam int STEP_W = (CT_W > 1) ? $clog2(CT_W) : 1;

    localparam logic [CT_W-1:0]    INIT_COUNT_V = CT_W'(INIT_COUNT);
    localparam logic [TOTAL_W-1:0] INIT_TOTAL_V = TOTAL_W'(INIT_TOTAL);
    localparam logic [STEP_W-1:0]  LAST_STEP    = STEP_W'(CT_W - 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_STOCK = 2'b01;
    localparam logic [1:0] ERR_FUNDS = 2'b10;
    localparam logic [1:0] ERR_OVF   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_CHK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [CT_W-1:0]    count_q,    count_d;
    logic [TOTAL_W-1:0] total_q,    total_d;
    logic [TOTAL_W-1:0] fprice_q,   fprice_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [1:0]         chk_code_q, chk_code_d;
    logic               op_q,       op_d;
    logic [CT_W-1:0]    qty_q,      qty_d;
    logic [CT_W-1:0]    mplier_q,   mplier_d;
    logic [TOTAL_W-1:0] mcand_q,    mcand_d;
    logic [TOTAL_W-1:0] acc_q,      acc_d;
    logic [STEP_W-1:0]  step_q,     step_d;

    logic [CT_W:0]      restock_sum;
    logic [TOTAL_W:0]   sell_sum;
    logic [1:0]         chk_code_c;

    // Limit checks, evaluated against the finished product in CHK.
    // The extra top bit of each sum is the overflow flag.
    always_comb begin
        restock_sum = {1'b0, count_q} + {1'b0, qty_q};
        sell_sum    = {1'b0, total_q} + {1'b0, acc_q};
        chk_code_c  = ERR_OK;
        if (op_q && (qty_q > count_q)) begin
            chk_code_c = ERR_STOCK;
        end else if (!op_q && restock_sum[CT_W]) begin
            chk_code_c = ERR_OVF;
        end else if (!op_q && (acc_q > total_q)) begin
            chk_code_c = ERR_FUNDS;
        end else if (op_q && sell_sum[TOTAL_W]) begin
            chk_code_c = ERR_FUNDS;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        total_d    = total_q;
        fprice_d   = fprice_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        chk_code_d = chk_code_q;
        op_d       = op_q;
        qty_d      = qty_q;
        mplier_d   = mplier_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        step_d     = step_q;

        case (state_q)
            S_IDLE: begin
                // load wins over req; the request stays pending.
                if (bus.load) begin
                    count_d = bus.count_in;
                    total_d = bus.total_in;
                end else if (bus.req) begin
                    op_d     = bus.op;
                    qty_d    = bus.qty;
                    mplier_d = bus.qty;
                    mcand_d  = TOTAL_W'(bus.uprice);
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                // One multiplier bit per cycle, LSB first.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                fprice_d   = acc_q;
                chk_code_d = chk_code_c;
                state_d    = S_DONE;
            end
            S_DONE: begin
                done_d     = 1'b1;
                err_d      = (chk_code_q != ERR_OK);
                err_code_d = chk_code_q;
                if (chk_code_q == ERR_OK) begin
                    if (op_q) begin
                        count_d = count_q - qty_q;
                        total_d = total_q + fprice_q;
                    end else begin
                        count_d = count_q + qty_q;
                        total_d = total_q - fprice_q;
                    end
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= INIT_COUNT_V;
            total_q    <= INIT_TOTAL_V;
            fprice_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_OK;
            chk_code_q <= ERR_OK;
            op_q       <= 1'b0;
            qty_q      <= '0;
            mplier_q   <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            total_q    <= total_d;
            fprice_q   <= fprice_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            chk_code_q <= chk_code_d;
            op_q       <= op_d;
            qty_q      <= qty_d;
            mplier_q   <= mplier_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
        end
    end

`ifdef LOW_STOCK_ALERT_EN
    logic low_stock_q, low_stock_d;
    logic count_wr;

    // Refreshed only on an actual count write, so it stays 0 out of reset.
    always_comb begin
        count_wr = ((state_q == S_IDLE) && bus.load) ||
                   ((state_q == S_DONE) && (chk_code_q == ERR_OK));
        low_stock_d = low_stock_q;
        if (count_wr) begin
            low_stock_d = (32'(count_d) <= LOW_THRESH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_stock_q <= 1'b0;
        end else begin
            low_stock_q <= low_stock_d;
        end
    end

    assign bus.low_stock = low_stock_q;
`else
    assign bus.low_stock = 1'b0;
`endif

    assign bus.ready    = (state_q == S_IDLE) && !bus.load;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
    assign bus.fprice   = fprice_q;
    assign bus.count    = count_q;
    assign bus.total    = total_q;
    assign bus.empty    = (count_q == '0);

endmodule

// File: tb/tb_fcims_txn_ctrl.sv
// Purpose: self-checking bench for fcims_txn_ctrl: vector table, load/req priority, reset mid-multiply, random sweep.
// Latency: expects done CT_W+2 edges after accept.
// Backpressure: waits (bounded) for ready before each request.
module tb_fcims_txn_ctrl;

    localparam int CT_W       = 4;
    localparam int PRICE_W    = 4;
    localparam int TOTAL_W    = 8;
    localparam int LOW_THRESH = 2;
    localparam int CNT_MAX    = (1 << CT_W) - 1;
    localparam int TOT_MAX    = (1 << TOTAL_W) - 1;
`ifdef LOW_STOCK_ALERT_EN
    localparam bit ALERT_EN = 1'b1;
`else
    localparam bit ALERT_EN = 1'b0;
`endif

    typedef struct {
        bit is_load;
        bit op;
        int qty;
        int up;
        int code;
        int fp;
        int cnt;
        int tot;
    } vec_t;

    typedef struct {
        int code;
        int fp;
        int cnt;
        int tot;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   m_count;
    int   m_total;
    bit   armed;
    exp_t sb[$];
    vec_t vt[$];

    fcims_txn_ctrl_if #(.CT_W(CT_W), .PRICE_W(PRICE_W), .TOTAL_W(TOTAL_W)) bus_if ();

    fcims_txn_ctrl #(
        .CT_W(CT_W), .PRICE_W(PRICE_W), .TOTAL_W(TOTAL_W),
        .INIT_COUNT(0), .INIT_TOTAL(0), .LOW_THRESH(LOW_THRESH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit exp_low(input int c);
        return ALERT_EN && armed && (c <= LOW_THRESH);
    endfunction

    function automatic vec_t mk(input bit l, input bit op, input int q, input int u,
                                input int code, input int fp, input int c, input int t);
        vec_t v;
        v.is_load = l; v.op = op; v.qty = q; v.up = u;
        v.code = code; v.fp = fp; v.cnt = c; v.tot = t;
        return v;
    endfunction

    // Reference behaviour from the bench's own view of count/total.
    function automatic exp_t model(input bit op, input int q, input int u);
        exp_t r;
        r.fp  = q * u;
        r.cnt = m_count;
        r.tot = m_total;
        if (op && q > m_count)                 r.code = 1;
        else if (!op && m_count + q > CNT_MAX) r.code = 3;
        else if (!op && r.fp > m_total)        r.code = 2;
        else if (op && m_total + r.fp > TOT_MAX) r.code = 2;
        else begin
            r.code = 0;
            if (op) begin r.cnt = m_count - q; r.tot = m_total + r.fp; end
            else    begin r.cnt = m_count + q; r.tot = m_total - r.fp; end
        end
        return r;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(bus_if.count), m_count);
        check({tag, "_total"}, 32'(bus_if.total), m_total);
        check({tag, "_empty"}, 32'(bus_if.empty), 32'(m_count == 0));
        check({tag, "_low"},   32'(bus_if.low_stock), 32'(exp_low(m_count)));
    endtask

    task automatic do_load(input int c, input int t);
        @(negedge clk);
        bus_if.load     = 1'b1;
        bus_if.count_in = CT_W'(c);
        bus_if.total_in = TOTAL_W'(t);
        #1 check("load_ready_low", 32'(bus_if.ready), 0);
        @(posedge clk);
        #1 bus_if.load = 1'b0;
        m_count = c;
        m_total = t;
        armed   = 1'b1;
        @(negedge clk);
        check_state("load");
    endtask

    task automatic wait_done();
        int   lat;
        bit   seen;
        exp_t e;
        logic held_err;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.done) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        check("latency", lat, CT_W + 2);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("err",      32'(bus_if.err), 32'(e.code != 0));
        check("err_code", 32'(bus_if.err_code), e.code);
        check("fprice",   32'(bus_if.fprice), e.fp);
        if (e.code == 0) armed = 1'b1;
        m_count = e.cnt;
        m_total = e.tot;
        check_state("done");
        held_err = bus_if.err;
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", 32'(bus_if.done), 0);
        check("err_held",   32'(bus_if.err), 32'(held_err));
    endtask

    task automatic issue(input bit op, input int q, input int u, input exp_t e);
        int w;
        @(negedge clk);
        w = 0;
        while (!bus_if.ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus_if.ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        bus_if.op     = op;
        bus_if.qty    = CT_W'(q);
        bus_if.uprice = PRICE_W'(u);
        bus_if.req    = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        #1;
        bus_if.req    = 1'b0;
        // Scramble operands; the controller must use the captured values.
        bus_if.op     = ~op;
        bus_if.qty    = CT_W'($urandom);
        bus_if.uprice = PRICE_W'($urandom);
        wait_done();
    endtask

    initial begin
        exp_t e;
        bit   seen;
        checks   = 0;
        failures = 0;
        armed    = 1'b0;
        m_count  = 0;
        m_total  = 0;
        bus_if.load     = 1'b0;
        bus_if.count_in = '0;
        bus_if.total_in = '0;
        bus_if.req      = 1'b0;
        bus_if.op       = 1'b0;
        bus_if.qty      = '0;
        bus_if.uprice   = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_ready",    32'(bus_if.ready), 1);
        check("rst_done",     32'(bus_if.done), 0);
        check("rst_err",      32'(bus_if.err), 0);
        check("rst_err_code", 32'(bus_if.err_code), 0);
        check("rst_fprice",   32'(bus_if.fprice), 0);
        check_state("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // {load, op, qty, uprice | code, fprice, count, total}; loads use qty/uprice slots unused.
        vt.push_back(mk(1, 0,  0,  0, 0,   0, 10,  20));
        vt.push_back(mk(0, 1,  3,  5, 0,  15,  7,  35));
        vt.push_back(mk(0, 1,  8,  1, 1,   8,  7,  35));
        vt.push_back(mk(0, 0,  4,  3, 0,  12, 11,  23));
        vt.push_back(mk(0, 0,  2, 15, 2,  30, 11,  23));
        vt.push_back(mk(0, 1,  0,  9, 0,   0, 11,  23));
        vt.push_back(mk(1, 0,  0,  0, 0,   0,  5, 250));
        vt.push_back(mk(0, 1,  2, 15, 2,  30,  5, 250));
        vt.push_back(mk(0, 1,  5,  1, 0,   5,  0, 255));
        vt.push_back(mk(0, 0, 15, 15, 0, 225, 15,  30));
        vt.push_back(mk(0, 0,  1,  0, 3,   0, 15,  30));
        vt.push_back(mk(1, 0,  0,  0, 0,   0,  3,  20));
        vt.push_back(mk(0, 0,  4,  5, 0,  20,  7,   0));
        vt.push_back(mk(1, 0,  0,  0, 0,   0,  3,  50));
        vt.push_back(mk(0, 1,  1,  1, 0,   1,  2,  51));
        vt.push_back(mk(0, 1,  2,  1, 0,   2,  0,  53));

        foreach (vt[i]) begin
            if (vt[i].is_load) begin
                do_load(vt[i].cnt, vt[i].tot);
            end else begin
                e.code = vt[i].code;
                e.fp   = vt[i].fp;
                e.cnt  = vt[i].cnt;
                e.tot  = vt[i].tot;
                issue(vt[i].op, vt[i].qty, vt[i].up, e);
            end
        end

        // load and req together: load applied, request taken one edge later.
        @(negedge clk);
        bus_if.load     = 1'b1;
        bus_if.count_in = CT_W'(14);
        bus_if.total_in = TOTAL_W'(100);
        bus_if.req      = 1'b1;
        bus_if.op       = 1'b0;
        bus_if.qty      = CT_W'(3);
        bus_if.uprice   = PRICE_W'(0);
        #1 check("ldreq_ready_low", 32'(bus_if.ready), 0);
        @(posedge clk);
        #1 bus_if.load = 1'b0;
        m_count = 14;
        m_total = 100;
        armed   = 1'b1;
        @(negedge clk);
        check("ldreq_not_taken", 32'(bus_if.ready), 1);
        check_state("ldreq");
        @(posedge clk);
        e.code = 3; e.fp = 0; e.cnt = 14; e.tot = 100;
        sb.push_back(e);
        #1;
        bus_if.req = 1'b0;
        check("ldreq_taken_next", 32'(bus_if.ready), 0);
        wait_done();

        // Reset during the second multiply cycle.
        @(negedge clk);
        bus_if.op     = 1'b1;
        bus_if.qty    = CT_W'(1);
        bus_if.uprice = PRICE_W'(1);
        bus_if.req    = 1'b1;
        @(posedge clk);
        #1 bus_if.req = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        m_count = 0;
        m_total = 0;
        armed   = 1'b0;
        check("midrst_done",   32'(bus_if.done), 0);
        check("midrst_fprice", 32'(bus_if.fprice), 0);
        check_state("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check("midrst_ready_after_release", 32'(bus_if.ready), 1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus_if.done) seen = 1'b1;
        end
        check("midrst_no_done", 32'(seen), 0);

        // Random sweep against the reference model.
        do_load(int'($urandom_range(0, CNT_MAX)), int'($urandom_range(0, TOT_MAX)));
        for (int n = 0; n < 12; n++) begin
            bit op;
            int q;
            int u;
            op = 1'($urandom_range(0, 1));
            q  = int'($urandom_range(0, CNT_MAX));
            u  = int'($urandom_range(0, (1 << PRICE_W) - 1));
            e  = model(op, q, u);
            issue(op, q, u, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
